// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: one-cycle arithmetic/logic ops, iterative 1-bit-per-cycle LSL/LSR,
// valid/ready handshake on both sides. Optional NZCV flags under `ALU_MC_FLAGS_EN.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_LSL  4'd4
`define ALU_LSR  4'd5
`define ALU_PASS 4'd6
`define ALU_NONE 4'd15
`endif

module alu_multicycle #(
   parameter int DATA_W  = 64,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_ctl,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               zero
`ifdef ALU_MC_FLAGS_EN
   ,
   input  logic               set_flags,
   output logic [3:0]         flags
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state;
   logic [DATA_W-1:0]   shreg;
   logic [SHAMT_W-1:0]  cnt;
   logic                shl;
   logic [DATA_W-1:0]   alu_res;
   logic [DATA_W-1:0]   shift_next;
   logic                is_shift;

   assign in_ready = (state == IDLE);

   always_comb begin
      alu_res  = '0;
      is_shift = (alu_ctl == `ALU_LSL) || (alu_ctl == `ALU_LSR);
      case (alu_ctl)
         `ALU_ADD:  alu_res = a + b;
         `ALU_SUB:  alu_res = a - b;
         `ALU_AND:  alu_res = a & b;
         `ALU_OR:   alu_res = a | b;
         `ALU_LSL,
         `ALU_LSR:  alu_res = a;       // only reaches the result when shamt == 0
         `ALU_PASS: alu_res = b;
         default:   alu_res = '0;
      endcase
   end

   assign shift_next = shl ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};

`ifdef ALU_MC_FLAGS_EN
   logic [DATA_W:0] sum_w;
   logic [DATA_W:0] diff_w;
   logic            c_next;
   logic            v_next;
   logic            flag_op;

   always_comb begin
      sum_w   = {1'b0, a} + {1'b0, b};
      diff_w  = {1'b0, a} - {1'b0, b};
      c_next  = 1'b0;
      v_next  = 1'b0;
      flag_op = 1'b0;
      case (alu_ctl)
         `ALU_ADD: begin
            c_next  = sum_w[DATA_W];
            v_next  = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
            flag_op = 1'b1;
         end
         `ALU_SUB: begin
            c_next  = ~diff_w[DATA_W];
            v_next  = (a[DATA_W-1] != b[DATA_W-1]) && (diff_w[DATA_W-1] != a[DATA_W-1]);
            flag_op = 1'b1;
         end
         `ALU_AND: flag_op = 1'b1;
         default:  flag_op = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         cnt       <= '0;
         shreg     <= '0;
         shl       <= 1'b0;
`ifdef ALU_MC_FLAGS_EN
         flags     <= 4'b0000;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && (shamt != '0)) begin
                     shreg <= a;
                     cnt   <= shamt;
                     shl   <= (alu_ctl == `ALU_LSL);
                     state <= SHIFT;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
`ifdef ALU_MC_FLAGS_EN
                     if (set_flags && flag_op)
                        flags <= {alu_res[DATA_W-1], (alu_res == '0), c_next, v_next};
`endif
                  end
               end
            end
            SHIFT: begin
               shreg <= shift_next;
               cnt   <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  result    <= shift_next;
                  zero      <= (shift_next == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle against a behavioural model.
// Flag checks are active when built with `ALU_MC_FLAGS_EN.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_LSL  4'd4
`define ALU_LSR  4'd5
`define ALU_PASS 4'd6
`define ALU_NONE 4'd15
`endif

module tb_alu_multicycle;

   localparam int DW = 64;
   localparam int SW = 6;
   localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [65:0] MINS = -66'sh0_8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_ctl;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [SW-1:0] shamt;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] result;
   logic          zero;
   logic          set_flags;
`ifdef ALU_MC_FLAGS_EN
   logic [3:0]    flags;
`endif

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [3:0]    exp_flags = 4'b0000;

   alu_multicycle #(.DATA_W(DW), .SHAMT_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctl   (alu_ctl),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
`ifdef ALU_MC_FLAGS_EN
      ,
      .set_flags (set_flags),
      .flags     (flags)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "bench did not terminate");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] ctl, input logic [63:0] av,
                                         input logic [63:0] bv, input logic [5:0] sh);
      case (ctl)
         `ALU_ADD:  return av + bv;
         `ALU_SUB:  return av - bv;
         `ALU_AND:  return av & bv;
         `ALU_OR:   return av | bv;
         `ALU_LSL:  return av << sh;
         `ALU_LSR:  return av >> sh;
         `ALU_PASS: return bv;
         default:   return 64'd0;
      endcase
   endfunction

   function automatic logic [3:0] next_flags(input logic [3:0] cur, input logic [3:0] ctl,
                                             input logic [63:0] av, input logic [63:0] bv,
                                             input logic sf);
      logic [63:0]        r;
      logic signed [65:0] sa;
      logic signed [65:0] sb;
      logic signed [65:0] s;
      logic               c;
      logic               v;
      if (!sf) return cur;
      r  = model(ctl, av, bv, 6'd0);
      sa = $signed({{2{av[63]}}, av});
      sb = $signed({{2{bv[63]}}, bv});
      if (ctl == `ALU_ADD) begin
         s = sa + sb;
         c = ({1'b0, av} + {1'b0, bv}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
         v = (s > MAXS) || (s < MINS);
      end else if (ctl == `ALU_SUB) begin
         s = sa - sb;
         c = (av >= bv);
         v = (s > MAXS) || (s < MINS);
      end else if (ctl == `ALU_AND) begin
         c = 1'b0;
         v = 1'b0;
      end else begin
         return cur;
      end
      return {r[63], (r == 64'd0), c, v};
   endfunction

   task automatic do_op(input string tag, input logic [3:0] ctl, input logic [63:0] av,
                        input logic [63:0] bv, input logic [5:0] sh, input logic sf,
                        input int unsigned stall);
      logic [63:0] er;
      int unsigned el;
      int unsigned lat;
      int unsigned lowc;
      int unsigned w;
      er = model(ctl, av, bv, sh);
      el = (((ctl == `ALU_LSL) || (ctl == `ALU_LSR)) && (sh != 0)) ? sh + 1 : 1;
      exp_flags = next_flags(exp_flags, ctl, av, bv, sf);
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_rdy"}, in_ready, 1);
      out_ready = (stall == 0);
      alu_ctl   = ctl;
      a         = av;
      b         = bv;
      shamt     = sh;
      set_flags = sf;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      shamt     = SW'($urandom);
      alu_ctl   = 4'($urandom);
      set_flags = ~sf;
      lat  = 1;
      lowc = in_ready ? 0 : 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
         if (!in_ready) lowc++;
      end
      check({tag, "_lat"}, lat, el);
      check({tag, "_busy"}, lowc, lat);
      check({tag, "_res"}, result, er);
      check({tag, "_zero"}, zero, er == 64'd0);
`ifdef ALU_MC_FLAGS_EN
      check({tag, "_flags"}, flags, exp_flags);
`endif
      for (int unsigned i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         alu_ctl  = `ALU_PASS;
         b        = ~er;
         @(negedge clk);
         check({tag, "_hold_v"}, out_valid, 1);
         check({tag, "_hold_r"}, result, er);
         check({tag, "_hold_z"}, zero, er == 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_ovld_off"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
   endtask

   initial begin
      logic [3:0] codes [9];
      logic [3:0] c;
      logic [63:0] ra;
      logic [63:0] rb;
      codes = '{`ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR, `ALU_LSL, `ALU_LSR,
                `ALU_PASS, `ALU_NONE, 4'd12};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_ctl = `ALU_NONE;
      a = '0; b = '0; shamt = '0; set_flags = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 1);
      check("rst_ovld", out_valid, 0);
      check("rst_res", result, 0);
      check("rst_zero", zero, 1);
`ifdef ALU_MC_FLAGS_EN
      check("rst_flags", flags, 4'b0000);
`endif
      rst = 1'b0;
      @(negedge clk);

      do_op("t1_add", `ALU_ADD, 64'd5, 64'd7, 6'd0, 1'b0, 0);
      do_op("t2_sub", `ALU_SUB, 64'd3, 64'd3, 6'd0, 1'b1, 0);
`ifdef ALU_MC_FLAGS_EN
      check("t2_nzcv", flags, 4'b0110);
`endif
      do_op("t3_lsl", `ALU_LSL, 64'd1, 64'd0, 6'd63, 1'b0, 0);
      do_op("t3_lsr0", `ALU_LSR, 64'h8000_0000_0000_0000, 64'd0, 6'd0, 1'b0, 0);
      do_op("t4_pass", `ALU_PASS, 64'd99, 64'd0, 6'd0, 1'b0, 5);

      // Reset in the middle of a shift drops the operation.
      alu_ctl = `ALU_LSR; a = 64'hF0; shamt = 6'd4; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_busy", in_ready, 0);
      rst = 1'b1;
      #1;
      check("t5_ready", in_ready, 1);
      check("t5_ovld", out_valid, 0);
      check("t5_res", result, 0);
      check("t5_zero", zero, 1);
      exp_flags = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_still_idle", out_valid, 0);
      do_op("t5_add", `ALU_ADD, 64'd1, 64'd1, 6'd0, 1'b0, 0);

      do_op("t6_add", `ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, 0);
`ifdef ALU_MC_FLAGS_EN
      check("t6_nzcv", flags, 4'b1001);
`endif
      do_op("t6_and", `ALU_AND, 64'hFF, 64'h0F, 6'd0, 1'b0, 0);
`ifdef ALU_MC_FLAGS_EN
      check("t6_hold", flags, 4'b1001);
`endif
      do_op("sub_borrow", `ALU_SUB, 64'd2, 64'd5, 6'd0, 1'b1, 0);
      do_op("lsr_max", `ALU_LSR, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd63, 1'b0, 1);

      for (int i = 0; i < 40; i++) begin
         c  = codes[$urandom_range(0, 8)];
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
         do_op("rnd", c, ra, rb, 6'($urandom_range(0, 63)), 1'($urandom),
               $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
